// File: rtl/control_barrido_pkg.sv
// Shared types and helpers for the 4-digit 7-segment scan controller.
package control_barrido_pkg;
  localparam int          N_DIG  = 4;
  localparam logic [3:0]  AN_OFF = 4'b1111;

  typedef logic [1:0] sel_t;

  // First enabled digit after sel, circularly; sel itself is the last candidate,
  // so a lone enabled digit or an empty mask both hold the current position.
  function automatic sel_t next_idx(sel_t sel, logic [3:0] mask);
    sel_t r;
    sel_t c;
    r = sel;
    for (int k = N_DIG; k >= 1; k--) begin
      c = sel + sel_t'(k);
      if (mask[c]) r = c;
    end
    return r;
  endfunction
endpackage

// File: rtl/control_barrido_if.sv
// Mode/button/mask inputs and select/anode/tick outputs of the scan controller.
interface control_barrido_if;
  import control_barrido_pkg::*;

  logic       modo_i;
  logic       btn_i;
  logic [3:0] en_mask_i;
  sel_t       sel_o;
  logic [3:0] an_o;
  logic       tick_o;

  modport master (output modo_i, btn_i, en_mask_i, input  sel_o, an_o, tick_o);
  modport slave  (input  modo_i, btn_i, en_mask_i, output sel_o, an_o, tick_o);
endinterface

// File: rtl/control_barrido_antirrebote.sv
// Push-button synchronizer + debouncer; emits a 1-cycle pulse on each debounced press.
module antirrebote #(
  parameter int DEB_MAX = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulso_o
);
  localparam int CW = (DEB_MAX > 1) ? $clog2(DEB_MAX) : 1;

  logic          sync1_q, sync2_q;
  logic          nivel_q, nivel_d, nivel_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    nivel_d = nivel_q;
    cnt_d   = '0;
    // Any return to the current level restarts the stability window.
    if (sync2_q != nivel_q) begin
      if (cnt_q == CW'(DEB_MAX - 1)) nivel_d = sync2_q;
      else                           cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      nivel_q      <= 1'b0;
      nivel_prev_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= btn_i;
      sync2_q      <= sync1_q;
      nivel_q      <= nivel_d;
      nivel_prev_q <= nivel_q;
      cnt_q        <= cnt_d;
    end
  end

  assign pulso_o = nivel_q & ~nivel_prev_q;
endmodule

// File: rtl/control_barrido.sv
// Digit scan controller: prescaled auto scan or button-stepped manual scan, skipping masked digits.
module control_barrido
  import control_barrido_pkg::*;
#(
  parameter int DIV_MAX = 100000,
  parameter int DEB_MAX = 1000000
) (
  input  logic               clk,
  input  logic               rst_n,
  control_barrido_if.slave   bus
);
  localparam int DW = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

  logic [DW-1:0] cnt_div_q, cnt_div_d;
  sel_t          sel_q, sel_d;
  logic          tick, paso, avance;

  antirrebote #(.DEB_MAX(DEB_MAX)) u_antirrebote (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (bus.btn_i),
    .pulso_o (paso)
  );

  // Prescaler free-runs in both modes so a mode switch keeps its phase.
  assign tick      = (cnt_div_q == DW'(DIV_MAX - 1));
  assign cnt_div_d = tick ? '0 : cnt_div_q + 1'b1;

  assign avance = bus.modo_i ? paso : tick;
  assign sel_d  = avance ? next_idx(sel_q, bus.en_mask_i) : sel_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_div_q <= '0;
      sel_q     <= '0;
    end else begin
      cnt_div_q <= cnt_div_d;
      sel_q     <= sel_d;
    end
  end

  assign bus.sel_o  = sel_q;
  assign bus.tick_o = tick;
  assign bus.an_o   = bus.en_mask_i[sel_q] ? ~(4'b0001 << sel_q) : AN_OFF;
endmodule

// File: tb/tb_control_barrido.sv
// Directed bench for control_barrido with a short prescaler and debounce window.
module tb_control_barrido;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  logic [3:0] an_tbl [4];

  control_barrido_if bus();

  control_barrido #(.DIV_MAX(4), .DEB_MAX(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Assert reset just after an edge, check reset outputs, release 1 ns after the next edge.
  task automatic do_reset(input logic [3:0] an_rst);
    rst_n = 1'b0;
    #1;
    chk("rst_sel", {30'd0, bus.sel_o}, 32'd0);
    chk("rst_an", {28'd0, bus.an_o}, {28'd0, an_rst});
    chk("rst_tick", {31'd0, bus.tick_o}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    an_tbl[0] = 4'b1110;
    an_tbl[1] = 4'b1101;
    an_tbl[2] = 4'b1011;
    an_tbl[3] = 4'b0111;
    rst_n         = 1'b0;
    bus.modo_i    = 1'b0;
    bus.btn_i     = 1'b0;
    bus.en_mask_i = 4'b1111;

    // Auto scan, full mask
    do_reset(4'b1110);
    for (int k = 1; k <= 20; k++) begin
      step(1);
      chk("auto_tick", {31'd0, bus.tick_o}, {31'd0, (k % 4) == 3});
      chk("auto_sel", {30'd0, bus.sel_o}, (k / 4) % 4);
      chk("auto_an", {28'd0, bus.an_o}, {28'd0, an_tbl[(k / 4) % 4]});
    end

    // Sparse mask 1010: digit 0 blank at reset, then 1,3,1,3
    bus.en_mask_i = 4'b1010;
    do_reset(4'b1111);
    step(3);
    chk("m1010_an0", {28'd0, bus.an_o}, 32'hF);
    step(1);
    chk("m1010_sel1", {30'd0, bus.sel_o}, 32'd1);
    chk("m1010_an1", {28'd0, bus.an_o}, 32'hD);
    step(4);
    chk("m1010_sel3", {30'd0, bus.sel_o}, 32'd3);
    chk("m1010_an3", {28'd0, bus.an_o}, 32'h7);
    step(4);
    chk("m1010_sel1b", {30'd0, bus.sel_o}, 32'd1);
    step(4);
    chk("m1010_sel3b", {30'd0, bus.sel_o}, 32'd3);
    bus.en_mask_i = 4'b0000;
    #1;
    chk("m0_an_now", {28'd0, bus.an_o}, 32'hF);
    step(3);
    chk("m0_tick", {31'd0, bus.tick_o}, 32'd1);
    step(1);
    chk("m0_sel_hold", {30'd0, bus.sel_o}, 32'd3);
    step(4);
    chk("m0_sel_hold2", {30'd0, bus.sel_o}, 32'd3);
    chk("m0_an", {28'd0, bus.an_o}, 32'hF);

    // Manual mode: glitches rejected, held press steps once
    bus.en_mask_i = 4'b1111;
    bus.modo_i    = 1'b1;
    do_reset(4'b1110);
    bus.btn_i = 1'b1; step(1); bus.btn_i = 1'b0; step(8);
    chk("glitch1", {30'd0, bus.sel_o}, 32'd0);
    bus.btn_i = 1'b1; step(2); bus.btn_i = 1'b0; step(8);
    chk("glitch2", {30'd0, bus.sel_o}, 32'd0);
    bus.btn_i = 1'b1;
    step(5);
    chk("press_edge5", {30'd0, bus.sel_o}, 32'd0);
    step(1);
    chk("press_edge6", {30'd0, bus.sel_o}, 32'd1);
    step(14);
    chk("press_held", {30'd0, bus.sel_o}, 32'd1);
    bus.btn_i = 1'b0; step(6);
    chk("release", {30'd0, bus.sel_o}, 32'd1);
    bus.btn_i = 1'b1; step(6);
    chk("press2", {30'd0, bus.sel_o}, 32'd2);
    bus.btn_i = 1'b0; step(6);

    // Mode switch keeps sel and prescaler phase
    bus.modo_i = 1'b0;
    do_reset(4'b1110);
    step(8);
    chk("sw_auto_sel2", {30'd0, bus.sel_o}, 32'd2);
    bus.modo_i = 1'b1;
    step(3);
    chk("sw_man_tick", {31'd0, bus.tick_o}, 32'd1);
    step(9);
    chk("sw_man_hold", {30'd0, bus.sel_o}, 32'd2);
    bus.btn_i = 1'b1; step(6);
    chk("sw_man_press", {30'd0, bus.sel_o}, 32'd3);
    bus.btn_i = 1'b0; step(6);
    bus.modo_i = 1'b0;
    step(3);
    chk("sw_back_tick", {31'd0, bus.tick_o}, 32'd1);
    chk("sw_back_pre", {30'd0, bus.sel_o}, 32'd3);
    step(1);
    chk("sw_back_wrap", {30'd0, bus.sel_o}, 32'd0);

    // Asynchronous reset mid-cycle
    step(8);
    chk("ar_sel2", {30'd0, bus.sel_o}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_sel", {30'd0, bus.sel_o}, 32'd0);
    chk("ar_an", {28'd0, bus.an_o}, 32'hE);
    chk("ar_tick", {31'd0, bus.tick_o}, 32'd0);
    #1;
    rst_n = 1'b1;
    step(2);
    chk("ar_notick", {31'd0, bus.tick_o}, 32'd0);
    step(1);
    chk("ar_tick3", {31'd0, bus.tick_o}, 32'd1);
    step(1);
    chk("ar_sel1", {30'd0, bus.sel_o}, 32'd1);

    // Step pulse consumed in auto mode must not advance after switching to manual
    bus.btn_i = 1'b1;
    step(6);
    chk("auto_btn_sel", {30'd0, bus.sel_o}, 32'd2);
    bus.modo_i = 1'b1;
    step(10);
    chk("auto_btn_noextra", {30'd0, bus.sel_o}, 32'd2);
    bus.btn_i = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
